// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single load/store requests onto a level-sensitive data RAM.
// Define ACCESS_COUNT_EN to add saturating read/write/error response counters.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [1:0]  ram_mode,
  input  logic [31:0] ram_dout
`ifdef ACCESS_COUNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_e;
  state_e      state_q, state_d;
  logic        write_q, write_d, signed_q, signed_d, err_q, err_d, second_q, second_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, hi_q, hi_d;
  logic [63:0] wdata_q, wdata_d, rdata_q, rdata_d, load_val;
  logic        misaligned, out_of_range;
  assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && |req_addr[1:0]) ||
                      (req_size == 2'd3 && |req_addr[2:0]);
  // 33-bit end address so requests near the top of the 32-bit space cannot wrap into range
  assign out_of_range = ({1'b0, req_addr} + (33'd1 << req_size)) > 33'(MEM_BYTES);
  assign load_val = size_q == 2'd3 ? {hi_q, ram_dout} :
                    size_q == 2'd2 ? {{32{signed_q & ram_dout[31]}}, ram_dout} :
                    size_q == 2'd1 ? {{48{signed_q & ram_dout[15]}}, ram_dout[15:0]} :
                                     {{56{signed_q & ram_dout[7]}}, ram_dout[7:0]};
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;
  assign ram_enable = state_q == STROBE;
  assign ram_rw     = write_q;
  assign ram_mode   = size_q == 2'd3 ? 2'd2 : size_q;
  assign ram_addr   = addr_q + {29'd0, second_q, 2'd0};
  // Doublewords are big-endian: most significant word goes to the lower address
  assign ram_din = size_q == 2'd3 ? (second_q ? wdata_q[31:0] : wdata_q[63:32]) :
                   size_q == 2'd2 ? wdata_q[31:0] :
                   size_q == 2'd1 ? {16'd0, wdata_q[15:0]} : {24'd0, wdata_q[7:0]};
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    second_d = second_q;
    hi_d     = hi_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d  = req_write;
        size_d   = req_size;
        signed_d = req_signed;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        second_d = 1'b0;
        err_d    = misaligned | out_of_range;
        rdata_d  = err_d ? '0 : rdata_q;
        state_d  = err_d ? RESP : SETUP;
      end
      SETUP: state_d = STROBE;
      STROBE: if (size_q == 2'd3 && !second_q) begin
        hi_d     = ram_dout;
        second_d = 1'b1;
        state_d  = SETUP;
      end else begin
        rdata_d = write_q ? '0 : load_val;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      second_q <= 1'b0;
      hi_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      second_q <= second_d;
      hi_q     <= hi_d;
      rdata_q  <= rdata_d;
    end
  end
`ifdef ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (resp_valid) begin
      if (err_q) err_count <= err_count + {15'd0, ~&err_count};
      else if (write_q) wr_count <= wr_count + {15'd0, ~&wr_count};
      else rd_count <= rd_count + {15'd0, ~&rd_count};
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random requests against a byte-array RAM and a shadow-memory reference.
module tb_mem_access_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, ram_enable, ram_rw;
  logic [63:0] resp_rdata;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic [1:0]  ram_mode;
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] en_addr_q[$], en_din_q[$];
  logic [1:0]  en_mode_q[$];
  logic        en_rw_q[$];
  bit          loaded = 1'b0;
  int          mode11 = 0;
  int          compared = 0, mismatched = 0;

  mem_access_ctrl #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_enable(ram_enable),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return i == 0 ? 8'h80 : i < 8 ? 8'(i) : 8'(i * 37 + 11);
  endfunction

  function automatic int mode_bytes(input logic [1:0] m);
    return m == 2'd0 ? 1 : m == 2'd1 ? 2 : 4;
  endfunction

  task automatic ram_write(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    int n = mode_bytes(m);
    for (int i = 0; i < n; i++) mem[8'(a + 32'(i))] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [1:0] m);
    logic [31:0] v = '0;
    for (int i = 0; i < mode_bytes(m); i++) v = (v << 8) | {24'd0, mem[8'(a + 32'(i))]};
    return v;
  endfunction

  // Behavioural RAM: big-endian, acts on whatever is presented while Enable is high
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
      loaded = 1'b1;
    end
    if (ram_mode == 2'b11) mode11++;
    if (ram_enable) begin
      en_addr_q.push_back(ram_addr);
      en_mode_q.push_back(ram_mode);
      en_rw_q.push_back(ram_rw);
      en_din_q.push_back(ram_din);
      if (ram_rw) ram_write(ram_addr, ram_mode, ram_din);
      else ram_dout <= ram_read(ram_addr, ram_mode);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | {56'd0, ref_mem[a + 32'(i)]};
    if (sg && sz != 2'd3 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [63:0] wd);
    int n = 1 << sz;
    int lat = 0, base, pulses, exp_pulses, exp_lat;
    logic err;
    logic [63:0] exp_rd, exp_din;
    err = ({32'd0, a} % 64'(n) != 0) || ({32'd0, a} + 64'(n) > 64'd256);
    exp_rd = (err || w) ? 64'd0 : ref_load(a, sz, sg);
    exp_lat = err ? 1 : sz == 2'd3 ? 5 : 3;
    exp_pulses = err ? 0 : sz == 2'd3 ? 2 : 1;
    base = en_addr_q.size();
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".err"}, 64'(resp_err), 64'(err));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    @(posedge clk);
    #1;
    chk({tag, ".pulse_end"}, 64'(resp_valid), 64'd0);
    chk({tag, ".ready_after"}, 64'(req_ready), 64'd1);
    pulses = en_addr_q.size() - base;
    chk({tag, ".enables"}, 64'(pulses), 64'(exp_pulses));
    for (int k = 0; k < exp_pulses && k < pulses; k++) begin
      exp_din = sz == 2'd3 ? (wd >> (32 * (1 - k))) & 64'hFFFF_FFFF : wd & ((64'd1 << (8 * n)) - 64'd1);
      chk($sformatf("%s.addr%0d", tag, k), 64'(en_addr_q[base + k]), 64'(a + 32'(4 * k)));
      chk($sformatf("%s.mode%0d", tag, k), 64'(en_mode_q[base + k]), sz == 2'd3 ? 64'd2 : 64'(sz));
      chk($sformatf("%s.rw%0d", tag, k), 64'(en_rw_q[base + k]), 64'(w));
      if (w) chk($sformatf("%s.din%0d", tag, k), 64'(en_din_q[base + k]), exp_din);
    end
    chk({tag, ".mode11"}, 64'(mode11), 64'd0);
    if (w && !err)
      for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk("rst.ram_enable", 64'(ram_enable), 64'd0);
    chk("rst.ram_rw", 64'(ram_rw), 64'd0);
    chk("rst.ram_addr", 64'(ram_addr), 64'd0);
    chk("rst.ram_din", 64'(ram_din), 64'd0);
    chk("rst.ram_mode", 64'(ram_mode), 64'd0);
    rst_n = 1'b1;
    do_req("ld_b_s", 1'b0, 2'd0, 1'b1, 32'd0, 64'd0);
    chk("ld_b_s.value", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_req("ld_b_u", 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
    do_req("ld_w4", 1'b0, 2'd2, 1'b0, 32'd4, 64'd0);
    chk("ld_w4.value", resp_rdata, 64'h0000_0000_0405_0607);
    do_req("ld_w0_s", 1'b0, 2'd2, 1'b1, 32'd0, 64'd0);
    do_req("st_h2", 1'b1, 2'd1, 1'b0, 32'd2, 64'hAAAA);
    do_req("ld_h2", 1'b0, 2'd1, 1'b0, 32'd2, 64'd0);
    chk("ld_h2.value", resp_rdata, 64'hAAAA);
    chk("ram.byte1", 64'(mem[1]), 64'h01);
    chk("ram.byte2", 64'(mem[2]), 64'hAA);
    chk("ram.byte3", 64'(mem[3]), 64'hAA);
    do_req("st_d8", 1'b1, 2'd3, 1'b0, 32'd8, 64'h1122_3344_5566_7788);
    do_req("ld_d8", 1'b0, 2'd3, 1'b0, 32'd8, 64'd0);
    chk("ld_d8.value", resp_rdata, 64'h1122_3344_5566_7788);
    do_req("err_w6", 1'b0, 2'd2, 1'b0, 32'd6, 64'd0);
    do_req("err_w100", 1'b0, 2'd2, 1'b0, 32'h100, 64'd0);
    do_req("ok_hFE", 1'b0, 2'd1, 1'b1, 32'hFE, 64'd0);
    do_req("ok_dF8", 1'b0, 2'd3, 1'b0, 32'hF8, 64'd0);
    do_req("err_dFC", 1'b0, 2'd3, 1'b0, 32'hFC, 64'd0);
    do_req("err_wrap", 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 64'h1234);
    // Reset in the middle of a strobe
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 10 && !ram_enable; c++) begin
      @(posedge clk);
      #1;
    end
    chk("midrst.in_strobe", 64'(ram_enable), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.enable_drop", 64'(ram_enable), 64'd0);
    chk("midrst.no_resp", 64'(resp_valid), 64'd0);
    chk("midrst.ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("midrst.quiet", 64'(resp_valid), 64'd0);
    end
    do_req("midrst.ld_w4", 1'b0, 2'd2, 1'b0, 32'd4, 64'd0);
    chk("midrst.value", resp_rdata, 64'h0405_0607);
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      a = r < 5 ? 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1) :
          r < 7 ? 32'($urandom_range(0, 255)) :
          r < 9 ? 32'd256 - (32'd1 << sz) + 32'($urandom_range(0, 1)) * (32'd1 << sz) : $urandom;
      do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, {$urandom, $urandom});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
